lock_code_sender: RTL and testbench
===================================

Name: lock_code_sender

Overview:
- Transmit side of the combination-lock digit interface: stores an operator-entered code of N_DIGITS decimal digits and replays it, one digit per handshake, to a lock-side checker.
- Sits beside the lock FSM in the top-level lab wrapper. SW[3:0] feeds digit_in; debounced KEY strobes drive load, start and clear; HEX0/HEX1 show progress.
- The lock consumes exactly one digit per accepted transfer.

Parameters:
- N_DIGITS, 6, digits per code.
- DIGIT_W, 4, width of one digit.
- MAX_DIGIT, 9, largest legal digit value; larger values are rejected.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- digit_in  in  DIGIT_W  digit to store on load.
- load  in  1  one-cycle strobe; store digit_in.
- start  in  1  one-cycle strobe; begin replay.
- clear  in  1  synchronous; discard code, return to IDLE.
- ready  in  1  lock can accept a digit this cycle.
- digit_out  out  DIGIT_W  digit offered to lock.
- valid  out  1  digit_out is valid.
- busy  out  1  high in SEND.
- done  out  1  high in DONE.
- err  out  1  one-cycle pulse on a rejected strobe.
- hex0  out  7  active-low segments; current digit.
- hex1  out  7  active-low segments; count (loaded digits, or digits sent).

Behaviour:
- Reset (async, rst_n=0): state IDLE; wr_ptr=0; rd_idx=0; code regs=0. Outputs: digit_out=0, valid=0, busy=0, done=0, err=0, hex0=off (1111111), hex1="0" (1000000).
- All outputs are registered, so each takes effect one clk after the causing edge.
- States:
  - IDLE: first legal load stores at index 0, sets wr_ptr=1, goes to LOAD.
  - LOAD: each legal load stores at code[wr_ptr] and increments wr_ptr. The load that fills index N_DIGITS-1 goes to ARMED.
  - ARMED: start sets rd_idx=0 and goes to SEND. load is ignored and pulses err.
  - SEND: valid=1, digit_out=code[rd_idx], busy=1. A transfer occurs on a cycle with valid&&ready.
    - Transfer with rd_idx<N_DIGITS-1: rd_idx++, stay in SEND. Back-to-back transfers are allowed, one per clk.
    - Transfer with rd_idx=N_DIGITS-1: go to DONE; valid drops the next cycle.
    - digit_out is stable while valid=1 and ready=0.
  - DONE: done=1, held. start replays the stored code (rd_idx=0, SEND).
- Illegal load (digit_in>MAX_DIGIT) in IDLE or LOAD: nothing stored, wr_ptr unchanged, err pulses one cycle.
- Illegal start (in IDLE or LOAD): ignored, err pulses.
- load or start in SEND: ignored, err pulses; the handshake is unaffected.
- Priority within one cycle: clear > start > load.
  - clear in any state: next state IDLE, wr_ptr=0, rd_idx=0, code regs=0, valid=0. Aborting mid-SEND is legal; the lock sees the code truncated.
  - start and load together in ARMED: start wins, err pulses for the dropped load.
- hex0:
  - Last stored digit in LOAD/ARMED.
  - code[rd_idx] in SEND.
  - Last sent digit in DONE.
  - off in IDLE.
- hex1:
  - wr_ptr in IDLE/LOAD/ARMED.
  - rd_idx in SEND.
  - N_DIGITS in DONE.
- Segment patterns, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - off=1111111
- wr_ptr and rd_idx are $clog2(N_DIGITS+1) bits wide. They never wrap: the pointer saturates via the state change.

Decomposition:
- Shared package lock_pkg:
  - state enum {IDLE, LOAD, ARMED, SEND, DONE}.
  - Seven-segment constants for digits 0-9 and SEG_OFF.
  - Default N_DIGITS and DIGIT_W.
- The lock FSM reuses the same package.
- One sub-module, seg7_decode: combinational 4-bit to 7-segment. Out-of-range input gives SEG_OFF. Instantiated twice, its outputs registered in lock_code_sender.

Test Plan:
- Load 7,0,3,2,6,2, one load per 3 cycles -> ARMED after 6th strobe; hex1=0000010 ("6"), hex0=0100100 ("2"), err never pulses.
- From ARMED, start with ready held 1 -> valid high 6 consecutive cycles, digit_out=7,0,3,2,6,2; then done=1, valid=0, busy=0.
- Replay with ready toggled 1,0,0,1,... -> digit_out stable during ready=0 stalls; exactly 6 transfers in order; done=1.
- digit_in=12 with load after 2 legal digits -> err pulses 1 cycle, wr_ptr stays 2; next legal load lands at index 2.
- start in LOAD -> err pulse, state unchanged; clear asserted mid-SEND after 3 transfers -> IDLE next cycle, valid=0, hex1="0".
- rst_n low asynchronously mid-SEND (between edges) -> valid, busy, done drop immediately; after release, load is required before start is accepted.

Source files
------------

// File: rtl/lock_pkg.sv
// lock_pkg
//   Shared definitions for the combination-lock digit interface: the sender
//   state encoding, seven-segment patterns (active-low, gfedcba) and the
//   default code geometry. The lock-side FSM imports the same package.
package lock_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ARMED,
      SEND,
      DONE
   } state_t;

   localparam int N_DIGITS_DEF = 6;
   localparam int DIGIT_W_DEF  = 4;

   localparam logic [6:0] SEG_0   = 7'b1000000;
   localparam logic [6:0] SEG_1   = 7'b1111001;
   localparam logic [6:0] SEG_2   = 7'b0100100;
   localparam logic [6:0] SEG_3   = 7'b0110000;
   localparam logic [6:0] SEG_4   = 7'b0011001;
   localparam logic [6:0] SEG_5   = 7'b0010010;
   localparam logic [6:0] SEG_6   = 7'b0000010;
   localparam logic [6:0] SEG_7   = 7'b1111000;
   localparam logic [6:0] SEG_8   = 7'b0000000;
   localparam logic [6:0] SEG_9   = 7'b0010000;
   localparam logic [6:0] SEG_OFF = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode
//   Combinational 4-bit value to active-low seven-segment pattern (gfedcba).
//   Values 10..15 blank the display, which the sender uses to show "off".
// Ports:
//   value  in   4  value to display
//   seg    out  7  active-low segment pattern
module seg7_decode
   import lock_pkg::*;
(
   input  logic [3:0] value,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_OFF;
      case (value)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/lock_code_sender.sv
// lock_code_sender
//   Stores an operator-entered code of N_DIGITS decimal digits and replays it
//   to the lock-side checker, one digit per valid/ready transfer.
//   Every output is registered from the next-state values, so outputs line
//   up with the state they describe.
// Ports:
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   digit_in   in   DIGIT_W  digit stored on load
//   load       in   1        strobe: store digit_in
//   start      in   1        strobe: begin replay
//   clear      in   1        synchronous discard, back to IDLE
//   ready      in   1        lock accepts a digit this cycle
//   digit_out  out  DIGIT_W  digit offered to the lock
//   valid      out  1        digit_out is valid
//   busy       out  1        replay in progress
//   done       out  1        replay complete
//   err        out  1        one-cycle pulse on a rejected strobe
//   hex0       out  7        current digit (active-low segments)
//   hex1       out  7        loaded / sent count (active-low segments)
module lock_code_sender
   import lock_pkg::*;
#(
   parameter int N_DIGITS  = N_DIGITS_DEF,
   parameter int DIGIT_W   = DIGIT_W_DEF,
   parameter int MAX_DIGIT = 9
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [DIGIT_W-1:0] digit_in,
   input  logic               load,
   input  logic               start,
   input  logic               clear,
   input  logic               ready,
   output logic [DIGIT_W-1:0] digit_out,
   output logic               valid,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [6:0]         hex0,
   output logic [6:0]         hex1
);

   localparam int PW = $clog2(N_DIGITS + 1);
   localparam logic [PW-1:0] LAST_IDX = PW'(N_DIGITS - 1);

   state_t             state_reg, state_next;
   logic [PW-1:0]      wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0]      rd_idx_reg, rd_idx_next;
   logic [DIGIT_W-1:0] code_reg  [N_DIGITS];
   logic [DIGIT_W-1:0] code_next [N_DIGITS];
   logic               err_next;
   logic               legal_digit;

   logic [DIGIT_W-1:0] digit_next;
   logic [3:0]         hex0_val, hex1_val;
   logic [6:0]         hex0_seg, hex1_seg;

   assign legal_digit = (digit_in <= DIGIT_W'(MAX_DIGIT));

   // Next-state logic. Priority within a cycle: clear > start > load.
   always_comb begin
      state_next  = state_reg;
      wr_ptr_next = wr_ptr_reg;
      rd_idx_next = rd_idx_reg;
      code_next   = code_reg;
      err_next    = 1'b0;

      if (clear) begin
         state_next  = IDLE;
         wr_ptr_next = '0;
         rd_idx_next = '0;
         for (int i = 0; i < N_DIGITS; i++) begin
            code_next[i] = '0;
         end
      end else begin
         case (state_reg)
            IDLE, LOAD: begin
               if (start) begin
                  err_next = 1'b1;
               end else if (load) begin
                  if (!legal_digit) begin
                     err_next = 1'b1;
                  end else begin
                     code_next[wr_ptr_reg] = digit_in;
                     wr_ptr_next           = wr_ptr_reg + PW'(1);
                     // Filling the last slot arms the sender, so wr_ptr
                     // never runs past N_DIGITS.
                     state_next = (wr_ptr_reg == LAST_IDX) ? ARMED : LOAD;
                  end
               end
            end
            ARMED: begin
               err_next = load;
               if (start) begin
                  rd_idx_next = '0;
                  state_next  = SEND;
               end
            end
            SEND: begin
               err_next = load | start;
               if (valid && ready) begin
                  if (rd_idx_reg == LAST_IDX) begin
                     state_next = DONE;
                  end else begin
                     rd_idx_next = rd_idx_reg + PW'(1);
                  end
               end
            end
            DONE: begin
               err_next = load;
               if (start) begin
                  rd_idx_next = '0;
                  state_next  = SEND;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Display and data selection from the values the registers are about to
   // take. A value of 4'hF blanks hex0 in IDLE.
   always_comb begin
      digit_next = '0;
      hex0_val   = 4'hF;
      hex1_val   = 4'(wr_ptr_next);
      case (state_next)
         LOAD, ARMED: begin
            hex0_val = 4'(code_next[wr_ptr_next - PW'(1)]);
         end
         SEND: begin
            digit_next = code_next[rd_idx_next];
            hex0_val   = 4'(code_next[rd_idx_next]);
            hex1_val   = 4'(rd_idx_next);
         end
         DONE: begin
            hex0_val = 4'(code_next[LAST_IDX]);
            hex1_val = 4'(N_DIGITS);
         end
         default: ;
      endcase
   end

   seg7_decode u_seg_hex0 (
      .value (hex0_val),
      .seg   (hex0_seg)
   );

   seg7_decode u_seg_hex1 (
      .value (hex1_val),
      .seg   (hex1_seg)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         wr_ptr_reg <= '0;
         rd_idx_reg <= '0;
         for (int i = 0; i < N_DIGITS; i++) begin
            code_reg[i] <= '0;
         end
         digit_out  <= '0;
         valid      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         hex0       <= SEG_OFF;
         hex1       <= SEG_0;
      end else begin
         state_reg  <= state_next;
         wr_ptr_reg <= wr_ptr_next;
         rd_idx_reg <= rd_idx_next;
         code_reg   <= code_next;
         digit_out  <= digit_next;
         valid      <= (state_next == SEND);
         busy       <= (state_next == SEND);
         done       <= (state_next == DONE);
         err        <= err_next;
         hex0       <= hex0_seg;
         hex1       <= hex1_seg;
      end
   end

endmodule

// File: tb/tb_lock_code_sender.sv
// tb_lock_code_sender
//   Self-checking bench for lock_code_sender. A behavioural model (phase,
//   queue of stored digits, count of digits sent) predicts every output
//   after each clock edge; directed steps cover the main scenarios and a
//   randomized section exercises strobe mixes and ready patterns.
module tb_lock_code_sender;

   localparam int ND      = 6;
   localparam int P_IDLE  = 0;
   localparam int P_LOAD  = 1;
   localparam int P_ARMED = 2;
   localparam int P_SEND  = 3;
   localparam int P_DONE  = 4;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic [3:0] digit_in = 4'd0;
   logic       load     = 1'b0;
   logic       start    = 1'b0;
   logic       clear    = 1'b0;
   logic       ready    = 1'b0;
   logic [3:0] digit_out;
   logic       valid, busy, done, err;
   logic [6:0] hex0, hex1;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   int ph;
   int code_q[$];
   int sent;
   bit m_err;
   int rx[$];
   int exp_rx[$];
   int err_cnt;

   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};
   int plan [6] = '{7, 0, 3, 2, 6, 2};

   lock_code_sender dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .digit_in  (digit_in),
      .load      (load),
      .start     (start),
      .clear     (clear),
      .ready     (ready),
      .digit_out (digit_out),
      .valid     (valid),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .hex0      (hex0),
      .hex1      (hex1)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "time limit");
   end

   function automatic logic [6:0] seg(int d);
      if (d < 0 || d > 9) return 7'b1111111;
      return seg_tab[d];
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      ph = P_IDLE;
      code_q.delete();
      sent  = 0;
      m_err = 0;
   endtask

   // Applies one clock edge worth of the sender's rules to the model.
   task automatic model_step();
      m_err = 0;
      if (clear) begin
         ph = P_IDLE;
         code_q.delete();
         sent = 0;
      end else begin
         case (ph)
            P_IDLE, P_LOAD: begin
               if (start) m_err = 1;
               else if (load) begin
                  if (digit_in > 9) m_err = 1;
                  else begin
                     code_q.push_back(int'(digit_in));
                     ph = (code_q.size() == ND) ? P_ARMED : P_LOAD;
                  end
               end
            end
            P_ARMED: begin
               if (load) m_err = 1;
               if (start) begin
                  sent = 0;
                  ph   = P_SEND;
               end
            end
            P_SEND: begin
               if (load || start) m_err = 1;
               if (ready) begin
                  exp_rx.push_back(code_q[sent]);
                  sent++;
                  if (sent == ND) ph = P_DONE;
               end
            end
            P_DONE: begin
               if (start) begin
                  sent = 0;
                  ph   = P_SEND;
               end
            end
            default: ;
         endcase
      end
   endtask

   task automatic check_all();
      logic [6:0] e_hex0, e_hex1;
      chk("valid", valid, ph == P_SEND);
      chk("busy", busy, ph == P_SEND);
      chk("done", done, ph == P_DONE);
      chk("err", err, m_err);
      if (ph == P_SEND) chk("digit_out", digit_out, code_q[sent]);
      case (ph)
         P_LOAD, P_ARMED: begin e_hex0 = seg(code_q[$]);    e_hex1 = seg(code_q.size()); end
         P_SEND:          begin e_hex0 = seg(code_q[sent]); e_hex1 = seg(sent);          end
         P_DONE:          begin e_hex0 = seg(code_q[ND-1]); e_hex1 = seg(ND);            end
         default:         begin e_hex0 = 7'b1111111;        e_hex1 = seg(code_q.size()); end
      endcase
      chk("hex0", hex0, e_hex0);
      chk("hex1", hex1, e_hex1);
   endtask

   // One clock: note a transfer the lock would see, step DUT and model, compare.
   task automatic cyc();
      if (valid === 1'b1 && ready === 1'b1) rx.push_back(int'(digit_out));
      @(posedge clk);
      model_step();
      #1;
      check_all();
      $display("cyc t=%0t ld=%0b st=%0b cl=%0b rdy=%0b din=%0d | v=%0b d=%0d busy=%0b done=%0b err=%0b hex0=%b hex1=%b",
               $time, load, start, clear, ready, digit_in, valid, digit_out, busy, done, err, hex0, hex1);
      if (err === 1'b1) err_cnt++;
   endtask

   task automatic strobe(bit ld, bit st, bit cl, int d);
      digit_in = 4'(d);
      load     = ld;
      start    = st;
      clear    = cl;
      cyc();
      load  = 1'b0;
      start = 1'b0;
      clear = 1'b0;
   endtask

   initial begin
      int nvalid;
      int r;
      logic [3:0] prev_d;
      bit stalled;

      // Reset state
      model_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      // Load 7,0,3,2,6,2 one strobe per 3 cycles
      err_cnt = 0;
      for (int i = 0; i < ND; i++) begin
         strobe(1, 0, 0, plan[i]);
         cyc();
         cyc();
      end
      chk("armed_hex1", hex1, 7'b0000010);
      chk("armed_hex0", hex0, 7'b0100100);
      chk("load_err_free", err_cnt, 0);

      // Replay with ready held high
      ready = 1'b1;
      rx.delete();
      nvalid = 0;
      strobe(0, 1, 0, 0);
      for (int k = 0; k < 20 && done !== 1'b1; k++) begin
         if (valid === 1'b1) nvalid++;
         cyc();
      end
      chk("send_done", done, 1);
      chk("valid_cycles", nvalid, ND);
      chk("rx_count", rx.size(), ND);
      for (int k = 0; k < ND && k < rx.size(); k++) chk("rx_digit", rx[k], plan[k]);

      // Replay from DONE with ready pattern 1,0,0 repeating
      rx.delete();
      ready = 1'b0;
      strobe(0, 1, 0, 0);
      for (int k = 0; k < 60 && done !== 1'b1; k++) begin
         ready   = (k % 3 == 0);
         stalled = (valid === 1'b1 && ready == 1'b0);
         prev_d  = digit_out;
         cyc();
         if (stalled && valid === 1'b1) chk("stall_stable", digit_out, prev_d);
      end
      chk("replay_done", done, 1);
      chk("replay_count", rx.size(), ND);
      for (int k = 0; k < ND && k < rx.size(); k++) chk("replay_digit", rx[k], plan[k]);

      // Illegal digit after two legal loads
      ready = 1'b0;
      strobe(0, 0, 1, 0);
      strobe(1, 0, 0, 4);
      strobe(1, 0, 0, 5);
      strobe(1, 0, 0, 12);
      chk("illegal_err", err, 1);
      chk("wr_ptr_held", hex1, 7'b0100100);
      cyc();
      chk("err_one_cycle", err, 0);
      strobe(1, 0, 0, 8);
      chk("idx2_hex0", hex0, 7'b0000000);
      chk("idx2_hex1", hex1, 7'b0110000);

      // start while loading is rejected
      strobe(0, 1, 0, 0);
      chk("start_in_load_err", err, 1);
      chk("start_in_load_hex1", hex1, 7'b0110000);
      chk("start_in_load_busy", busy, 0);

      // Finish the code, send three digits, then clear mid-SEND
      strobe(1, 0, 0, 1);
      strobe(1, 0, 0, 9);
      strobe(1, 0, 0, 3);
      strobe(0, 1, 0, 0);
      rx.delete();
      ready = 1'b1;
      repeat (3) cyc();
      ready = 1'b0;
      strobe(0, 0, 1, 0);
      chk("clear_valid", valid, 0);
      chk("clear_hex1", hex1, 7'b1000000);
      chk("trunc_count", rx.size(), 3);
      if (rx.size() == 3) chk("trunc_last", rx[2], 8);

      // Randomized strobes and ready patterns
      rx.delete();
      exp_rx.delete();
      for (int k = 0; k < 500; k++) begin
         r     = $urandom_range(0, 19);
         ready = 1'($urandom_range(0, 1));
         if (r < 6 && ph != P_DONE) strobe(1, 0, 0, $urandom_range(0, 11));
         else if (r < 8) strobe(0, 1, 0, 0);
         else if (r == 8) begin
            ready = 1'b0;
            strobe(0, 0, 1, 0);
         end else cyc();
      end
      chk("rand_rx_count", rx.size(), exp_rx.size());
      for (int k = 0; k < rx.size() && k < exp_rx.size(); k++) chk("rand_rx_digit", rx[k], exp_rx[k]);

      // Asynchronous reset between edges while sending
      ready = 1'b0;
      strobe(0, 0, 1, 0);
      for (int i = 0; i < ND; i++) strobe(1, 0, 0, $urandom_range(0, 9));
      strobe(0, 1, 0, 0);
      chk("pre_reset_valid", valid, 1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_valid", valid, 0);
      chk("async_busy", busy, 0);
      chk("async_done", done, 0);
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      strobe(0, 1, 0, 0);
      chk("post_reset_start_err", err, 1);
      chk("post_reset_busy", busy, 0);
      strobe(1, 0, 0, 3);
      chk("post_reset_hex1", hex1, 7'b1111001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
